// File: rtl/booth_r4_mul_seq.sv
// Sequential signed radix-4 Booth multiplier, one Booth digit per cycle.
// Optional BOOTH_ZERO_BYPASS_EN: zero operands finish in one cycle.
module booth_r4_mul_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int AW = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [AW-1:0]      r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_m1;
    logic [WIDTH-1:0]   r_m;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic [2:0]         w_digit;
    logic [AW-1:0]      w_m_ext;
    logic [AW-1:0]      w_m2;
    logic [AW-1:0]      w_addend;
    logic [AW-1:0]      w_sum;
    logic [AW-1:0]      w_acc_n;
    logic [WIDTH-1:0]   w_q_n;
    logic               w_last;
    logic               w_bypass;

`ifdef BOOTH_ZERO_BYPASS_EN
    assign w_bypass = (multiplicand == '0) || (multiplier == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_digit = {r_q[1:0], r_q_m1};
    assign w_m_ext = {{2{r_m[WIDTH-1]}}, r_m};
    assign w_m2    = w_m_ext << 1;
    assign w_last  = (r_cnt == LAST);

    always_comb begin
        w_addend = '0;
        unique case (w_digit)
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = -w_m2;
            3'b101, 3'b110: w_addend = -w_m_ext;
            default:        w_addend = '0;
        endcase
    end

    // Sum feeds the 2-bit arithmetic shift across {acc,q,q_m1}
    assign w_sum   = r_acc + w_addend;
    assign w_acc_n = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_q_n   = {w_sum[1:0], r_q[WIDTH-1:2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (op_clear) begin
                    w_state_n = S_IDLE;
                end else if (op_start) begin
                    w_state_n = w_bypass ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_clear) begin
                    w_state_n = S_IDLE;
                end else if (w_last) begin
                    w_state_n = S_DONE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == S_EXEC);
        op_done = (r_state == S_DONE);
    end

    assign result = r_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_q_m1   <= 1'b0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (op_clear) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_q_m1 <= 1'b0;
            r_cnt  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (op_start) begin
                        r_m    <= multiplicand;
                        r_q    <= multiplier;
                        r_acc  <= '0;
                        r_q_m1 <= 1'b0;
                        r_cnt  <= '0;
                        if (w_bypass) begin
                            r_result <= '0;
                        end
                    end
                end
                S_EXEC: begin
                    r_acc  <= w_acc_n;
                    r_q    <= w_q_n;
                    r_q_m1 <= r_q[1];
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= {w_acc_n[WIDTH-1:0], w_q_n};
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Randomised and directed bench for booth_r4_mul_seq (WIDTH=64).
// Reference product is plain signed 128-bit multiplication.
module tb_booth_r4_mul_seq;

    logic         clk;
    logic         reset;
    logic         op_start;
    logic         op_clear;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic         busy;
    logic         op_done;
    logic [127:0] result;

    int vec;
    int err;

    localparam int FULL_LAT  = 33;
    localparam int FULL_BUSY = 32;

    booth_r4_mul_seq #(.WIDTH(64), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .op_done      (op_done),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model(input logic [63:0] a,
                                           input logic [63:0] b);
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Pulse op_start; lat counts edges from the accept edge until op_done.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         output int lat, output int bcnt,
                         output logic first_done);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        op_start     = 1'b0;
        multiplicand = rnd64();
        multiplier   = rnd64();
        first_done   = op_done;
        lat  = 1;
        bcnt = 0;
        while (!op_done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            multiplicand = rnd64();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vec++;
        if ({busy, op_done} !== 2'b00 || result !== '0) begin
            err++;
            $display("FAIL reset: busy=%b done=%b result=%h want 0/0/0",
                     busy, op_done, result);
        end
    endtask

    task automatic test_directed();
        logic [63:0] ta [7];
        logic [63:0] tb [7];
        int lat, bcnt;
        logic fd;
        ta = '{64'd3, '1, 64'h7FFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'd7, 64'h0123_4567_89AB_CDEF};
        tb = '{64'd5, '1, '1,
               64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFF7, 64'h8000_0000_0000_0001};
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], lat, bcnt, fd);
            vec++;
            if (result !== model(ta[i], tb[i])) begin
                err++;
                $display("FAIL directed[%0d]: result=%h want %h",
                         i, result, model(ta[i], tb[i]));
            end
            vec++;
            if (lat != FULL_LAT || bcnt != FULL_BUSY) begin
                err++;
                $display("FAIL latency[%0d]: lat=%0d busy=%0d want %0d/%0d",
                         i, lat, bcnt, FULL_LAT, FULL_BUSY);
            end
        end
    endtask

    task automatic test_stable();
        logic [127:0] exp;
        int lat, bcnt;
        logic fd;
        logic bad;
        do_op(64'd3, 64'd5, lat, bcnt, fd);
        exp = 128'd15;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            multiplicand = rnd64();
            multiplier   = rnd64();
            if (result !== exp || op_done !== 1'b1) bad = 1'b1;
        end
        vec++;
        if (bad) begin
            err++;
            $display("FAIL hold: result=%h done=%b want %h/1",
                     result, op_done, exp);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        int lat, bcnt;
        logic fd;
        for (int i = 0; i < 24; i++) begin
            a = rnd64();
            b = rnd64();
            if (i % 6 == 1) a = {{48{a[15]}}, a[15:0]};
            if (i % 6 == 2) b = {{56{b[7]}}, b[7:0]};
            if (a == '0) a = 64'd1;
            if (b == '0) b = 64'd1;
            do_op(a, b, lat, bcnt, fd);
            vec++;
            if (result !== model(a, b) || lat != FULL_LAT) begin
                err++;
                $display("FAIL random[%0d]: %h*%h result=%h lat=%0d want %h/%0d",
                         i, a, b, result, lat, model(a, b), FULL_LAT);
            end
        end
    endtask

    task automatic test_clear();
        logic [127:0] prior;
        logic seen;
        prior = result;
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 64'd7;
        multiplier   = 64'd9;
        @(negedge clk);
        op_start = 1'b0;
        repeat (10) @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        vec++;
        if (busy !== 1'b0 || op_done !== 1'b0 || result !== prior) begin
            err++;
            $display("FAIL clear: busy=%b done=%b result=%h want 0/0/%h",
                     busy, op_done, result, prior);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (op_done || busy) seen = 1'b1;
        end
        vec++;
        if (seen || result !== prior) begin
            err++;
            $display("FAIL clear_idle: activity=%b result=%h want 0/%h",
                     seen, result, prior);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 64'hFFFF_FFFF_FFFF_FFFD;
        multiplier   = 64'd11;
        @(negedge clk);
        op_start = 1'b0;
        lat = 1;
        while (!op_done && lat < 100) begin
            if (lat == 12) begin
                op_start     = 1'b1;
                multiplicand = 64'd100;
                multiplier   = 64'd100;
            end else begin
                op_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        op_start = 1'b0;
        vec++;
        if (lat != FULL_LAT || result !== model(64'hFFFF_FFFF_FFFF_FFFD, 64'd11)) begin
            err++;
            $display("FAIL ignore_start: lat=%0d result=%h want %0d/%h",
                     lat, result, FULL_LAT,
                     model(64'hFFFF_FFFF_FFFF_FFFD, 64'd11));
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic fd;
        do_op(64'd12, 64'd12, lat, bcnt, fd);
        do_op(64'hFFFF_FFFF_FFFF_FFFA, 64'd4, lat, bcnt, fd);
        vec++;
        if (fd !== 1'b0) begin
            err++;
            $display("FAIL b2b_drop: done=%b want 0", fd);
        end
        vec++;
        if (result !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE8 ||
            lat != FULL_LAT) begin
            err++;
            $display("FAIL b2b: result=%h lat=%0d want -24/%0d",
                     result, lat, FULL_LAT);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 64'd5;
        multiplier   = 64'd5;
        @(negedge clk);
        op_start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vec++;
        if ({busy, op_done} !== 2'b00 || result !== '0) begin
            err++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h want 0/0/0",
                     busy, op_done, result);
        end
    endtask

    task automatic test_zero();
        int lat, bcnt;
        logic fd;
        int exp_lat, exp_busy;
`ifdef BOOTH_ZERO_BYPASS_EN
        exp_lat  = 1;
        exp_busy = 0;
`else
        exp_lat  = FULL_LAT;
        exp_busy = FULL_BUSY;
`endif
        do_op(64'd9, 64'd9, lat, bcnt, fd);
        do_op(64'd0, 64'h1234, lat, bcnt, fd);
        vec++;
        if (result !== '0 || lat != exp_lat || bcnt != exp_busy) begin
            err++;
            $display("FAIL zero: result=%h lat=%0d busy=%0d want 0/%0d/%0d",
                     result, lat, bcnt, exp_lat, exp_busy);
        end
        do_op(64'h5555, 64'd0, lat, bcnt, fd);
        vec++;
        if (result !== '0 || lat != exp_lat) begin
            err++;
            $display("FAIL zero_q: result=%h lat=%0d want 0/%0d",
                     result, lat, exp_lat);
        end
    endtask

    initial begin
        vec          = 0;
        err          = 0;
        reset        = 1'b1;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        test_reset();
        test_directed();
        test_stable();
        test_random();
        test_clear();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
